// File: rtl/modulo_matriz_reg_param.sv
// Frame register for the LED dot-matrix: full/per-pixel writes, column scrolling,
// and a free-running row-multiplex scanner that drives one row at a time.
module modulo_matriz_reg_param #(
    parameter int unsigned COLS     = 5,
    parameter int unsigned ROWS     = 7,
    parameter int unsigned SCAN_DIV = 1000,
    localparam int unsigned W       = COLS * ROWS,
    localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [W-1:0]    m_in,
    input  logic            load,
    input  logic [W-1:0]    bit_we,
    input  logic            shift_en,
    input  logic            shift_dir,
    input  logic            wrap,
    output logic [W-1:0]    m_out,
    output logic [RW-1:0]   row_idx,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_data
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);

    logic [W-1:0]    frame_q, frame_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] row_cur, row_nxt;

    // Each row is a COLS-wide slice, leftmost pixel in its MSB.
    always_comb begin
        frame_d = frame_q;
        row_cur = '0;
        row_nxt = '0;
        if (load) begin
            frame_d = m_in;
        end else if (|bit_we) begin
            frame_d = (frame_q & ~bit_we) | (m_in & bit_we);
        end else if (shift_en) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                row_cur = frame_q[W-1-r*COLS -: COLS];
                if (!shift_dir) begin
                    row_nxt = {row_cur[COLS-2:0], wrap & row_cur[COLS-1]};
                end else begin
                    row_nxt = {wrap & row_cur[0], row_cur[COLS-1:1]};
                end
                frame_d[W-1-r*COLS -: COLS] = row_nxt;
            end
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        row_d   = row_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            row_d   = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frame_q <= '0;
            presc_q <= '0;
            row_q   <= '0;
        end else begin
            frame_q <= frame_d;
            presc_q <= presc_d;
            row_q   <= row_d;
        end
    end

    // Decoded straight from the live frame, so writes to the scanned row show immediately.
    always_comb begin
        row_sel  = '0;
        col_data = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            if (row_q == RW'(r)) begin
                row_sel[r] = 1'b1;
                col_data   = frame_q[W-1-r*COLS -: COLS];
            end
        end
    end

    assign m_out   = frame_q;
    assign row_idx = row_q;

endmodule

// File: tb/tb_modulo_matriz_reg_param.sv
// Self-checking bench: constant vector table, hand sequences for scroll/reset/scan,
// and random traffic against a pixel-array reference model.
module tb_modulo_matriz_reg_param;

    localparam int COLS     = 5;
    localparam int ROWS     = 7;
    localparam int SCAN_DIV = 4;
    localparam int W        = COLS * ROWS;
    localparam int RW       = 3;

    logic            clk = 1'b0;
    logic            clr;
    logic [W-1:0]    m_in, bit_we, m_out;
    logic            load, shift_en, shift_dir, wrap;
    logic [RW-1:0]   row_idx;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;

    modulo_matriz_reg_param #(.COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .clr       (clr),
        .m_in      (m_in),
        .load      (load),
        .bit_we    (bit_we),
        .shift_en  (shift_en),
        .shift_dir (shift_dir),
        .wrap      (wrap),
        .m_out     (m_out),
        .row_idx   (row_idx),
        .row_sel   (row_sel),
        .col_data  (col_data)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Reference model: pixel grid plus count of clocks since reset.
    bit pix [ROWS][COLS];
    int cyc;

    typedef struct {
        logic         ld;
        logic [W-1:0] we;
        logic [W-1:0] d;
        logic         sh;
        logic         dir;
        logic         wr;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    function automatic logic [W-1:0] model_frame();
        logic [W-1:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[W-1-(r*COLS+c)] = pix[r][c];
        return v;
    endfunction

    function automatic int model_row();
        return (cyc / SCAN_DIV) % ROWS;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                pix[r][c] = 1'b0;
        cyc = 0;
    endtask

    task automatic model_step(input logic ld, input logic [W-1:0] we, input logic [W-1:0] d,
                              input logic sh, input logic dir, input logic wr);
        bit old [ROWS][COLS];
        old = pix;
        if (ld || we != '0) begin
            for (int i = 0; i < W; i++)
                if (ld || we[i]) pix[(W-1-i)/COLS][(W-1-i)%COLS] = d[i];
        end else if (sh) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    if (!dir) pix[r][c] = (c < COLS-1) ? old[r][c+1] : (wr ? old[r][0] : 1'b0);
                    else      pix[r][c] = (c > 0) ? old[r][c-1] : (wr ? old[r][COLS-1] : 1'b0);
                end
        end
        cyc++;
    endtask

    task automatic check_all(input string tag);
        int row;
        logic [COLS-1:0] exp_cols;
        logic [ROWS-1:0] exp_sel;
        row = model_row();
        for (int c = 0; c < COLS; c++) exp_cols[COLS-1-c] = pix[row][c];
        exp_sel = '0;
        exp_sel[row] = 1'b1;
        check({tag, ".m_out"}, 64'(m_out), 64'(model_frame()));
        check({tag, ".row_idx"}, 64'(row_idx), 64'(row));
        check({tag, ".row_sel"}, 64'(row_sel), 64'(exp_sel));
        check({tag, ".col_data"}, 64'(col_data), 64'(exp_cols));
    endtask

    // Drive just after a falling edge, clock once, sample on the next falling edge.
    task automatic apply(input string tag, input logic ld, input logic [W-1:0] we,
                         input logic [W-1:0] d, input logic sh, input logic dir,
                         input logic wr);
        load = ld; bit_we = we; m_in = d; shift_en = sh; shift_dir = dir; wrap = wr;
        @(posedge clk);
        model_step(ld, we, d, sh, dir, wr);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        apply(tag, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset");
        clr = 1'b0;
    endtask

    localparam logic [W-1:0] ONES = {W{1'b1}};

    initial begin
        logic [63:0] r64;
        logic [W-1:0] rnd_we;

        load = 0; bit_we = '0; m_in = '0; shift_en = 0; shift_dir = 0; wrap = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Scanner free-run: 30 idle clocks covers the 6->0 wrap at clock 28.
        for (int k = 0; k < 30; k++) idle("scan");
        check("scan.row_at_30", 64'(row_idx), 64'd0);

        tbl[0] = '{1'b1, '0,   35'h4_0000_0001, 1'b0, 1'b0, 1'b0, 35'h4_0000_0001};
        tbl[1] = '{1'b1, '0,   ONES,            1'b0, 1'b0, 1'b0, 35'h7_FFFF_FFFF};
        tbl[2] = '{1'b0, 35'h1, '0,             1'b1, 1'b0, 1'b1, 35'h7_FFFF_FFFE};
        tbl[3] = '{1'b1, ONES, 35'h5_5555_5555, 1'b1, 1'b1, 1'b1, 35'h5_5555_5555};
        tbl[4] = '{1'b0, '0,   '0,              1'b0, 1'b0, 1'b0, 35'h5_5555_5555};
        tbl[5] = '{1'b1, '0,   35'h4_0000_0000, 1'b0, 1'b0, 1'b0, 35'h4_0000_0000};
        tbl[6] = '{1'b0, '0,   '0,              1'b1, 1'b0, 1'b1, 35'h0_4000_0000};
        tbl[7] = '{1'b0, '0,   '0,              1'b1, 1'b1, 1'b1, 35'h4_0000_0000};
        tbl[8] = '{1'b0, '0,   '0,              1'b1, 1'b0, 1'b0, 35'h0_0000_0000};
        tbl[9] = '{1'b0, 35'h400, ONES,         1'b1, 1'b1, 1'b0, 35'h0_0000_0400};
        for (int i = 0; i < 10; i++) begin
            apply($sformatf("vec%0d", i), tbl[i].ld, tbl[i].we, tbl[i].d, tbl[i].sh,
                  tbl[i].dir, tbl[i].wr);
            check($sformatf("vec%0d.table", i), 64'(m_out), 64'(tbl[i].exp));
        end

        // Wrapped left scroll returns the original frame after COLS clocks.
        apply("rot.load", 1'b1, '0, 35'h4_0000_0001, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= COLS; k++) begin
            apply($sformatf("rot%0d", k), 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
            if (k == 1) check("rot.first", 64'(m_out[W-1 -: COLS]), 64'(5'b00001));
        end
        check("rot.back", 64'(m_out), 64'(35'h4_0000_0001));

        // Asynchronous clear mid-scroll, away from any clock edge.
        apply("pre_clr", 1'b1, '0, ONES, 1'b0, 1'b0, 1'b0);
        shift_en = 1'b1; wrap = 1'b1;
        #2 clr = 1'b1;
        #1;
        check("clr.m_out", 64'(m_out), 64'd0);
        check("clr.row_idx", 64'(row_idx), 64'd0);
        check("clr.row_sel", 64'(row_sel), 64'd1);
        check("clr.col_data", 64'(col_data), 64'd0);
        shift_en = 1'b0; wrap = 1'b0;
        @(negedge clk);
        do_reset();

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            r64 = {$urandom(), $urandom()};
            rnd_we = ($urandom_range(0, 3) == 0) ? r64[W-1:0] & W'({$urandom(), $urandom()}) : '0;
            r64 = {$urandom(), $urandom()};
            apply("rnd", $urandom_range(0, 9) == 0, rnd_we, r64[W-1:0],
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
